// File: rtl/ssd_marquee.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_marquee
//  Purpose  : Writable message buffer and scroll sequencer that feeds the
//             four 15-bit segment words consumed by scan_ctl.
//             The message is scrolled through a four-digit window, forward
//             or reverse, on each step tick, with run/hold/idle control.
//  Ports    : clk, rst_n (async, active low)
//             step      - one-clk scroll tick
//             wr_en/wr_addr/wr_data - buffer write port (IDLE only)
//             msg_len   - message length, latched on start from IDLE
//             dir       - 0 forward, 1 reverse
//             start/stop- control pulses (stop wins when both are high)
//             busy      - state is not IDLE (registered)
//             wrap      - one-clk pulse when the pointer wraps
//             SSDa..SSDd- registered window, active-low segment patterns
//  Macro    : SSD_MARQUEE_BLINK_EN - when defined, steps in HOLD toggle a
//             blink flag that blanks the display while set.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_marquee #(
    parameter int MSG_LEN = 8,
    parameter int PTR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [14:0]      wr_data,
    input  logic [PTR_W-1:0] msg_len,
    input  logic             dir,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             wrap,
    output logic [14:0]      SSDa,
    output logic [14:0]      SSDb,
    output logic [14:0]      SSDc,
    output logic [14:0]      SSDd
);

    // Length needs one extra bit so MSG_LEN == 2**PTR_W is representable.
    localparam int               LEN_W   = PTR_W + 1;
    localparam int               DEPTH   = 2 ** PTR_W;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MSG_LEN);
    localparam logic [14:0]      BLANK   = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wrap_q, wrap_d;
    logic             busy_q;
    // Sized to the full address space so any wr_addr indexes legally;
    // entries at or above MSG_LEN are never written and stay constant.
    logic [14:0]      mem_q [DEPTH];
    logic [14:0]      ssd_q [4];

    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W-1:0] ptr_last;
    logic             ptr_at_last;
    logic [PTR_W-1:0] win_idx [4];
    logic             wr_ok;
    logic             blank_win;

`ifdef SSD_MARQUEE_BLINK_EN
    logic             blink_q, blink_d;
`endif

    assign len_clamp   = (msg_len == '0 || {1'b0, msg_len} > LEN_MAX)
                         ? LEN_MAX : {1'b0, msg_len};
    assign ptr_last    = len_q - 1'b1;
    assign ptr_at_last = ({1'b0, ptr_q} == ptr_last);
    assign wr_ok       = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < LEN_MAX);

    // Window indices are built as a chain of increment-modulo-len steps,
    // which wraps repeatedly for short messages without a divider.
    always_comb begin
        win_idx[0] = ptr_q;
        for (int i = 1; i < 4; i++) begin
            win_idx[i] = ({1'b0, win_idx[i-1]} == ptr_last) ? '0
                                                            : win_idx[i-1] + 1'b1;
        end
    end

    // Next-state logic. Priority inside each state: stop, start, step;
    // a step coinciding with a state change is therefore dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
`ifdef SSD_MARQUEE_BLINK_EN
        blink_d = blink_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    ptr_d   = '0;
                    len_d   = len_clamp;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (start) begin
                    ptr_d = '0;
                end else if (step) begin
                    if (!dir) begin
                        if (ptr_at_last) begin
                            ptr_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else begin
                        if (ptr_q == '0) begin
                            ptr_d  = ptr_last[PTR_W-1:0];
                            wrap_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q - 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (start) begin
                    state_d = RUN;
`ifdef SSD_MARQUEE_BLINK_EN
                end else if (step) begin
                    blink_d = ~blink_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
`ifdef SSD_MARQUEE_BLINK_EN
        if (state_d != HOLD) begin
            blink_d = 1'b0;
        end
`endif
    end

`ifdef SSD_MARQUEE_BLINK_EN
    assign blank_win = (state_q == IDLE) || blink_q;
`else
    assign blank_win = (state_q == IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= LEN_MAX;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BLANK;
            end
            for (int i = 0; i < 4; i++) begin
                ssd_q[i] <= BLANK;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d != IDLE);
            if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
            // Display follows the pointer/state one clock later.
            for (int i = 0; i < 4; i++) begin
                ssd_q[i] <= blank_win ? BLANK : mem_q[win_idx[i]];
            end
        end
    end

`ifdef SSD_MARQUEE_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    assign busy = busy_q;
    assign wrap = wrap_q;
    assign SSDa = ssd_q[0];
    assign SSDb = ssd_q[1];
    assign SSDc = ssd_q[2];
    assign SSDd = ssd_q[3];

endmodule
`default_nettype wire

// File: tb/tb_ssd_marquee.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_marquee
//  Purpose  : Self-checking bench for ssd_marquee. A reference model pushes
//             the expected registered outputs into a queue each clock; a
//             monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_marquee;

    localparam int MSG_LEN = 8;
    localparam int PTR_W   = 4;

    logic             clk;
    logic             rst_n;
    logic             step;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [14:0]      wr_data;
    logic [PTR_W-1:0] msg_len;
    logic             dir;
    logic             start;
    logic             stop;
    logic             busy;
    logic             wrap;
    logic [14:0]      SSDa, SSDb, SSDc, SSDd;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_marquee #(.MSG_LEN(MSG_LEN), .PTR_W(PTR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .msg_len(msg_len),
        .dir    (dir),
        .start  (start),
        .stop   (stop),
        .busy   (busy),
        .wrap   (wrap),
        .SSDa   (SSDa),
        .SSDb   (SSDb),
        .SSDc   (SSDc),
        .SSDd   (SSDd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0][14:0] ssd;
        logic             busy;
        logic             wrap;
    } exp_t;

    exp_t        sbq[$];
    int          m_mode;   // 0 idle, 1 run, 2 hold
    int          m_ptr;
    int          m_len;
    bit          m_blink;
    logic [14:0] m_mem [16];

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_mode  = 0;
            m_ptr   = 0;
            m_len   = MSG_LEN;
            m_blink = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 15'h7FFF;
        end else begin
            // Display reflects the state as it was before this edge.
            for (int i = 0; i < 4; i++)
                e.ssd[i] = (m_mode == 0 || m_blink) ? 15'h7FFF : m_mem[(m_ptr + i) % m_len];
            e.wrap = 1'b0;
            if (wr_en && m_mode == 0 && int'(wr_addr) < MSG_LEN)
                m_mem[wr_addr] = wr_data;
            case (m_mode)
                0: if (start && !stop) begin
                    m_mode = 1;
                    m_ptr  = 0;
                    m_len  = (msg_len == 0 || int'(msg_len) > MSG_LEN) ? MSG_LEN : int'(msg_len);
                end
                1: if (stop) m_mode = 2;
                   else if (start) m_ptr = 0;
                   else if (step) begin
                       if (!dir) begin
                           e.wrap = (m_ptr == m_len - 1);
                           m_ptr  = (m_ptr + 1) % m_len;
                       end else begin
                           e.wrap = (m_ptr == 0);
                           m_ptr  = (m_ptr + m_len - 1) % m_len;
                       end
                   end
                default: if (stop) begin
                       m_mode = 0;
                       m_ptr  = 0;
                   end else if (start) m_mode = 1;
`ifdef SSD_MARQUEE_BLINK_EN
                   else if (step) m_blink = !m_blink;
`endif
            endcase
            if (m_mode != 2) m_blink = 0;
            e.busy = (m_mode != 0);
            sbq.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            check("rst_ssd", {17'd0, SSDa}, 32'h7FFF);
            check("rst_ssd", {17'd0, SSDd}, 32'h7FFF);
            check("rst_busy_wrap", {30'd0, busy, wrap}, 32'd0);
        end else if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("SSDa", {17'd0, SSDa}, {17'd0, e.ssd[0]});
            check("SSDb", {17'd0, SSDb}, {17'd0, e.ssd[1]});
            check("SSDc", {17'd0, SSDc}, {17'd0, e.ssd[2]});
            check("SSDd", {17'd0, SSDd}, {17'd0, e.ssd[3]});
            check("busy", {31'd0, busy}, {31'd0, e.busy});
            check("wrap", {31'd0, wrap}, {31'd0, e.wrap});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string name, input logic [14:0] a, input logic [14:0] b,
                        input logic [14:0] c, input logic [14:0] d);
        @(negedge clk);
        check(name, {2'd0, SSDa, SSDb}, {2'd0, a, b});
        check(name, {2'd0, SSDc, SSDd}, {2'd0, c, d});
    endtask

    task automatic write_mem(input int a, input logic [14:0] d);
        wr_en   = 1'b1;
        wr_addr = PTR_W'(a);
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; dir = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Message 7FF0..7FF7, plus an out-of-range write that must be dropped.
        for (int i = 0; i < 8; i++) write_mem(i, 15'h7FF0 + 15'(i));
        write_mem(9, 15'h0000);

        msg_len = 4'd8;
        pulse_start();
        cyc(1);
        dchk("win_start", 15'h7FF0, 15'h7FF1, 15'h7FF2, 15'h7FF3);
        cyc(1);
        step = 1'b1; cyc(5); step = 1'b0;
        cyc(1);
        dchk("win_step5", 15'h7FF5, 15'h7FF6, 15'h7FF7, 15'h7FF0);
        cyc(1);
        step = 1'b1; cyc(3); step = 1'b0;     // 5 -> 7 -> 0 (wrap)
        dir = 1'b1; step = 1'b1; cyc(1);      // 0 -> 7 (wrap)
        step = 1'b0; dir = 1'b0;
        cyc(2);

        // Short message with repeated wrap in the window.
        stop = 1'b1; cyc(2); stop = 1'b0;     // RUN -> HOLD -> IDLE
        write_mem(0, 15'h7FF0);
        write_mem(1, 15'h7FF1);
        msg_len = 4'd2;
        pulse_start();
        cyc(1);
        dchk("win_len2", 15'h7FF0, 15'h7FF1, 15'h7FF0, 15'h7FF1);
        cyc(1);

        // HOLD: steps and writes must not disturb the frozen window.
        stop = 1'b1; cyc(1); stop = 1'b0;
        step = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 15'h0000;
        cyc(4);
        step = 1'b0; wr_en = 1'b0;
        cyc(1);
        dchk("win_hold", 15'h7FF0, 15'h7FF1, 15'h7FF0, 15'h7FF1);
        cyc(1);
        pulse_start();                         // resume
        start = 1'b1; stop = 1'b1; cyc(1);     // stop wins -> HOLD
        start = 1'b0; stop = 1'b0;
        cyc(2);

        // Randomised phase.
        for (int n = 0; n < 800; n++) begin
            step    = ($urandom_range(0, 1) == 0);
            dir     = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 15) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = PTR_W'($urandom_range(0, 15));
            wr_data = 15'($urandom);
            msg_len = PTR_W'($urandom_range(0, 15));
            cyc(1);
        end
        step = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; dir = 1'b0;

        // Asynchronous reset in the middle of a scroll.
        stop = 1'b1; cyc(2); stop = 1'b0;
        for (int i = 0; i < 8; i++) write_mem(i, 15'h7FF0 + 15'(i));
        msg_len = 4'd8;
        pulse_start();
        step = 1'b1; cyc(3); step = 1'b0;
        cyc(2);
        dchk("win_prerst", 15'h7FF3, 15'h7FF4, 15'h7FF5, 15'h7FF6);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {2'd0, SSDa, SSDb}, {2'd0, 15'h7FFF, 15'h7FFF});
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
